// File: rtl/zorder_scan_gen.sv
// Scan-order index generator: walks an N x N block in raster, Z-order or column order.
// Define ZSCAN_ABORT_EN to let sob restart a scan that is already in progress.
module zorder_scan_gen #(
   parameter int LOG2_N = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sob,
   input  logic [1:0]            mode,
   input  logic                  idx_rdy,
   output logic                  idx_vld,
   output logic [2*LOG2_N-1:0]   idx,
   output logic                  idx_last,
   output logic                  busy,
   output logic                  done
);

   localparam int W = 2 * LOG2_N;
   localparam logic [W-1:0] K_MAX = {W{1'b1}};

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t       state, state_nxt;
   logic [W-1:0] k, k_nxt;
   logic [1:0]   mode_r, mode_nxt;
   logic         vld_nxt;
   logic         done_nxt;
   logic         accept;

   // Z-order interleaves k: even bits form x, odd bits form y.
   function automatic logic [W-1:0] map_idx(input logic [W-1:0] kk, input logic [1:0] m);
      logic [LOG2_N-1:0] x;
      logic [LOG2_N-1:0] y;
      logic [W-1:0]      r;
      x = '0;
      y = '0;
      r = kk;
      case (m)
         2'b01: begin
            for (int i = 0; i < LOG2_N; i++) begin
               x[i] = kk[2*i];
               y[i] = kk[2*i+1];
            end
            r = {y, x};
         end
         2'b10:   r = {kk[LOG2_N-1:0], kk[W-1:LOG2_N]};
         default: r = kk;
      endcase
      return r;
   endfunction

   assign accept = idx_vld & idx_rdy;

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      mode_nxt  = mode_r;
      vld_nxt   = idx_vld;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (sob) begin
               state_nxt = ACTIVE;
               k_nxt     = '0;
               mode_nxt  = mode;
               vld_nxt   = 1'b1;
            end
         end
         ACTIVE: begin
            // A sob landing on the final accepted beat chains straight into the next scan.
            if (accept && (k == K_MAX)) begin
               done_nxt = 1'b1;
               k_nxt    = '0;
               if (sob) begin
                  mode_nxt = mode;
                  vld_nxt  = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  vld_nxt   = 1'b0;
               end
            end
`ifdef ZSCAN_ABORT_EN
            else if (sob) begin
               k_nxt    = '0;
               mode_nxt = mode;
               vld_nxt  = 1'b1;
            end
`endif
            else if (accept) begin
               k_nxt = k + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed from next-state values so they are registered yet current.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         k        <= '0;
         mode_r   <= 2'b00;
         idx_vld  <= 1'b0;
         idx      <= '0;
         idx_last <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         k        <= k_nxt;
         mode_r   <= mode_nxt;
         idx_vld  <= vld_nxt;
         idx      <= map_idx(k_nxt, mode_nxt);
         idx_last <= vld_nxt && (k_nxt == K_MAX);
         busy     <= (state_nxt == ACTIVE);
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_zorder_scan_gen.sv
// Self-checking bench for zorder_scan_gen: table vectors, scoreboard monitor and corner sequences.
// Honours ZSCAN_ABORT_EN to pick the expected abort behaviour.
module tb_zorder_scan_gen;

   localparam int LOG2_N = 3;
   localparam int N      = 1 << LOG2_N;
   localparam int TOTAL  = N * N;
   localparam int W      = 2 * LOG2_N;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sob;
   logic [1:0]   mode;
   logic         idx_rdy;
   logic         idx_vld;
   logic [W-1:0] idx;
   logic         idx_last;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   zorder_scan_gen #(.LOG2_N(LOG2_N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sob      (sob),
      .mode     (mode),
      .idx_rdy  (idx_rdy),
      .idx_vld  (idx_vld),
      .idx      (idx),
      .idx_last (idx_last),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      logic [W-1:0] idx;
      logic         last;
   } beat_t;

   typedef struct {
      logic [1:0]   mode;
      int           k;
      logic [W-1:0] exp;
   } vec_t;

   beat_t        sbq[$];
   beat_t        expBeat;
   vec_t         vecs[12];
   int           tests = 0;
   int           fails = 0;
   int           beatCount = 0;
   logic [W-1:0] captured[TOTAL];
   logic         prevAcceptLast = 1'b0;
   logic         prevStall = 1'b0;
   logic [W-1:0] prevIdx = '0;
   logic         prevLast = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference mapping: Z-order descends quadrant by quadrant, column is a transpose.
   function automatic logic [W-1:0] modelIdx(input int k, input logic [1:0] m);
      int x, y, d;
      x = 0;
      y = 0;
      case (m)
         2'b01: begin
            for (int lvl = 0; lvl < LOG2_N; lvl++) begin
               d = (k >> (2 * lvl)) % 4;
               x += (d % 2) << lvl;
               y += (d / 2) << lvl;
            end
            return W'(y * N + x);
         end
         2'b10:   return W'((k % N) * N + (k / N));
         default: return W'(k);
      endcase
   endfunction

   task automatic pushScan(input logic [1:0] m);
      beat_t b;
      for (int k = 0; k < TOTAL; k++) begin
         b.idx  = modelIdx(k, m);
         b.last = (k == TOTAL - 1);
         sbq.push_back(b);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [1:0] m, input logic r);
      @(posedge clk);
      #1;
      sob     = s;
      mode    = m;
      idx_rdy = r;
   endtask

   task automatic waitDone(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (done) return;
      end
      checkOutput("wait_done_timeout", 0, 1);
   endtask

   task automatic waitIdx(input logic [W-1:0] target, input logic wantLast, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (idx_vld && (wantLast ? idx_last : (idx == target))) return;
      end
      checkOutput("wait_idx_timeout", 0, 1);
   endtask

   // Monitor: pops the scoreboard on every accepted beat, checks stall hold and done timing.
   always @(negedge clk) begin
      if (!rst_n) begin
         prevAcceptLast = 1'b0;
         prevStall      = 1'b0;
      end else begin
         checkOutput("done_pulse", done, prevAcceptLast);
         if (prevStall) begin
            checkOutput("stall_idx", idx, prevIdx);
            checkOutput("stall_vld", idx_vld, 1);
            checkOutput("stall_last", idx_last, prevLast);
         end
         prevAcceptLast = 1'b0;
         if (idx_vld && idx_rdy) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_beat", idx, 32'hFFFF_FFFF);
            end else begin
               expBeat = sbq.pop_front();
               checkOutput("scan_idx", idx, expBeat.idx);
               checkOutput("scan_last", idx_last, expBeat.last);
               prevAcceptLast = expBeat.last;
            end
            if (beatCount < TOTAL) captured[beatCount] = idx;
            beatCount++;
         end
         prevStall = idx_vld && !idx_rdy;
         prevIdx   = idx;
         prevLast  = idx_last;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{2'b01, 3,  6'd9};
      vecs[1]  = '{2'b01, 5,  6'd3};
      vecs[2]  = '{2'b01, 63, 6'd63};
      vecs[3]  = '{2'b01, 2,  6'd8};
      vecs[4]  = '{2'b01, 6,  6'd10};
      vecs[5]  = '{2'b10, 0,  6'd0};
      vecs[6]  = '{2'b10, 1,  6'd8};
      vecs[7]  = '{2'b10, 2,  6'd16};
      vecs[8]  = '{2'b10, 10, 6'd17};
      vecs[9]  = '{2'b10, 63, 6'd63};
      vecs[10] = '{2'b00, 10, 6'd10};
      vecs[11] = '{2'b11, 17, 6'd17};

      rst_n   = 1'b1;
      sob     = 1'b0;
      mode    = 2'b00;
      idx_rdy = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset_vld", idx_vld, 0);
      checkOutput("reset_idx", idx, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      #9 rst_n = 1'b1;

      // Stall-free scan in every mode, then check table vectors against captured beats.
      for (int m = 0; m < 4; m++) begin
         beatCount = 0;
         applyStimulus(1'b1, 2'(m), 1'b1);
         pushScan(2'(m));
         applyStimulus(1'b0, 2'(m), 1'b1);
         checkOutput("start_vld", idx_vld, 1);
         checkOutput("start_busy", busy, 1);
         checkOutput("start_idx", idx, 0);
         waitDone(TOTAL + 10);
         checkOutput("scan_beats", beatCount, TOTAL);
         checkOutput("scan_queue_empty", sbq.size(), 0);
         checkOutput("end_vld", idx_vld, 0);
         checkOutput("end_busy", busy, 0);
         for (int v = 0; v < 12; v++)
            if (vecs[v].mode == 2'(m))
               checkOutput($sformatf("vec_m%0d_k%0d", m, vecs[v].k), captured[vecs[v].k], vecs[v].exp);
      end

      // Random backpressure with mode wiggling mid-scan.
      beatCount = 0;
      applyStimulus(1'b1, 2'b01, 1'b1);
      pushScan(2'b01);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
            sob     = 1'b0;
            idx_rdy = 1'($urandom_range(0, 1));
            mode    = 2'($urandom_range(0, 3));
         end
         checkOutput("stall_done_seen", seen, 1);
      end
      idx_rdy = 1'b1;
      checkOutput("stall_beats", beatCount, TOTAL);
      checkOutput("stall_queue_empty", sbq.size(), 0);

      // Back-to-back: sob on the final accepted beat.
      applyStimulus(1'b1, 2'b00, 1'b1);
      pushScan(2'b00);
      applyStimulus(1'b0, 2'b00, 1'b1);
      waitIdx('0, 1'b1, TOTAL + 10);
      sob  = 1'b1;
      mode = 2'b10;
      pushScan(2'b10);
      @(posedge clk);
      #1;
      sob  = 1'b0;
      mode = 2'b00;
      checkOutput("b2b_vld", idx_vld, 1);
      checkOutput("b2b_idx", idx, 0);
      checkOutput("b2b_done", done, 1);
      checkOutput("b2b_busy", busy, 1);
      checkOutput("b2b_last", idx_last, 0);
      waitDone(TOTAL + 10);
      checkOutput("b2b_queue_empty", sbq.size(), 0);

      // sob mid-scan at k=20.
      applyStimulus(1'b1, 2'b00, 1'b1);
      pushScan(2'b00);
      applyStimulus(1'b0, 2'b00, 1'b1);
      waitIdx(6'd20, 1'b0, TOTAL);
      sob  = 1'b1;
      mode = 2'b01;
      @(posedge clk);
      #1;
      sob = 1'b0;
`ifdef ZSCAN_ABORT_EN
      sbq.delete();
      pushScan(2'b01);
      checkOutput("abort_idx", idx, 0);
      checkOutput("abort_vld", idx_vld, 1);
`else
      checkOutput("ignore_idx", idx, 21);
      checkOutput("ignore_vld", idx_vld, 1);
`endif
      checkOutput("midsob_done", done, 0);
      waitDone(2 * TOTAL);
      checkOutput("midsob_queue_empty", sbq.size(), 0);

      // Asynchronous reset at k=30, then a fresh scan.
      applyStimulus(1'b1, 2'b00, 1'b1);
      pushScan(2'b00);
      applyStimulus(1'b0, 2'b00, 1'b1);
      waitIdx(6'd30, 1'b0, TOTAL);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_vld", idx_vld, 0);
      checkOutput("rst_idx", idx, 0);
      checkOutput("rst_last", idx_last, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("post_rst_idle_vld", idx_vld, 0);
      checkOutput("post_rst_idle_busy", busy, 0);
      beatCount = 0;
      applyStimulus(1'b1, 2'b10, 1'b1);
      pushScan(2'b10);
      applyStimulus(1'b0, 2'b10, 1'b1);
      checkOutput("post_rst_first_idx", idx, 0);
      waitDone(TOTAL + 10);
      checkOutput("post_rst_beats", beatCount, TOTAL);
      checkOutput("post_rst_queue_empty", sbq.size(), 0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
